boothmul_r4: RTL and testbench
==============================

Name: boothmul_r4

Overview:
- Parametrised radix-4 Booth multiplier; successor to the radix-2 sequential Booth multiplier in the control loop.
- Retires 2 multiplier bits per clock, so it takes about half the cycles of the radix-2 unit.
- Adds a per-operation signed/unsigned mode, odd operand widths, and a valid/ready handshake on both input and output.
- Used by the control loop and any arithmetic datapath that can tolerate multi-cycle products.

Parameters:
- A1_LEN, 32: multiplicand (a1) width; must be >= 2.
- A2_LEN, 32: multiplier (a2) width; must be >= 2; odd or even.
- Derived, internal only:
  - A2E = A2_LEN+1 rounded up to even.
  - ITER = A2E/2.
  - Counter sized to hold ITER.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  a1/a2/sgn are valid.
- in_ready  out  1  block can accept an operation.
- a1  in  A1_LEN  multiplicand.
- a2  in  A2_LEN  multiplier.
- sgn  in  1  1 = both operands two's complement; 0 = both unsigned.
- out_valid  out  1  outn holds a finished product.
- out_ready  in  1  consumer accepts outn.
- outn  out  A1_LEN+A2_LEN  product, two's complement if sgn=1, unsigned otherwise.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - in_ready=0, out_valid=0, outn=0, counter=0.
  - in_ready goes to 1 on the first clk edge after rst deasserts.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Acceptance occurs at an edge with in_valid&&in_ready.
  - At acceptance: capture a1, a2 and sgn; in_ready<=0; counter<=0; go to RUN.
  - Operand extension: a2 is extended to A2E bits (sign bit if sgn, else zeros) and a 0 is appended below the LSB. a1 is extended by 2 bits (sign or zero) to allow for ±2M without overflow.
  - in_valid while not ready is ignored; no input buffering.
- RUN: one recoding step per edge on triplet {b(i+1), b(i), b(i-1)}, then the partial-product register shifts arithmetically right by 2. Recoding:
  - 000 or 111 -> +0
  - 001 or 010 -> +M
  - 011 -> +2M
  - 100 -> -2M
  - 101 or 110 -> -M
- RUN exit: after ITER steps, go to DONE at the same edge as the last step; outn<=exact product; out_valid<=1.
- Latency: out_valid rises ITER edges after the acceptance edge. Example: A2_LEN=32 -> 17 edges; A2_LEN=8 -> 5 edges.
- DONE:
  - outn and out_valid hold stable while out_ready=0.
  - At an edge with out_ready=1: out_valid<=0, in_ready<=1, go to IDLE.
  - A new operation can be accepted at the earliest 1 edge after the handoff, giving throughput 1 per ITER+2 cycles.
- outn keeps its last value after the handoff until the next product completes. Consumers must qualify outn with out_valid.
- Arithmetic:
  - Result is exact and never truncated: |product| fits in A1_LEN+A2_LEN bits in both modes, including the signed case -2^(A1_LEN-1) × -2^(A2_LEN-1).
  - Internal register width is A1_LEN+2+A2E+1 bits. No overflow or wrap-around is permitted.
- Inputs a1/a2/sgn may change freely after acceptance without affecting the result in flight.
- rst asserted mid-RUN or in DONE: the operation is aborted, all outputs take their reset values, and no out_valid pulse is produced for the aborted operation.
- A pending in_valid held across reset is accepted normally once in_ready returns to 1.

Test Plan:
- A1_LEN=A2_LEN=8, sgn=1, a1=0x80, a2=0x80 -> out_valid exactly 5 edges after acceptance; outn=0x4000 (16384).
- A1_LEN=A2_LEN=8, sgn=0, a1=0xFF, a2=0xFF -> outn=0xFE01 (65025). The same operands with sgn=1 -> outn=0x0001.
- A1_LEN=8, A2_LEN=7 (odd), sgn=1, a1=0x80, a2=0x40 (-64) -> ITER=4; outn=0x2000 (8192). With sgn=0 and the same bits -> outn=128×64=0x2000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outn and out_valid stable and in_ready=0 throughout. Raise out_ready -> out_valid falls and in_ready rises on the same edge. Next accepted op: a1=0xFF (-1), a2=0x7F, sgn=1 -> outn=0xFF81.
- Reset mid-RUN: assert rst 2 edges after acceptance -> outputs immediately 0 (async) and no out_valid afterwards. After release, in_ready=1 one edge later; a new op 3×5 gives outn=15.
- Random regression (32×32, 10k ops, mixed sgn, random in_valid/out_ready gaps) against a reference model -> all products exact. Include corner operands 0, ±1, the most negative value and all-ones.

Source files
------------

// File: rtl/boothmul_r4.sv
// Sequential radix-4 Booth multiplier: retires two multiplier bits per clock.
// Supports signed and unsigned operands, odd widths, and valid/ready on both sides.
module boothmul_r4 #(
  parameter int A1_LEN = 32,
  parameter int A2_LEN = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [A1_LEN-1:0]        a1,
  input  logic [A2_LEN-1:0]        a2,
  input  logic                     sgn,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [A1_LEN+A2_LEN-1:0] outn
);

  localparam int A2E  = ((A2_LEN + 1) % 2 == 0) ? (A2_LEN + 1) : (A2_LEN + 2);
  localparam int ITER = A2E / 2;
  localparam int AW   = A1_LEN + 2;
  localparam int PW   = AW + A2E + 1;
  localparam int OW   = A1_LEN + A2_LEN;
  localparam int CW   = $clog2(ITER + 1);
  localparam int XW   = A2E - A2_LEN;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state_r, state_s;
  logic [PW-1:0]   p_r, p_next_s;
  logic [AW-1:0]   m_r, pp_s;
  logic [AW:0]     sum_s;
  logic [CW-1:0]   cnt_r;
  logic            in_ready_r, in_ready_s;
  logic            out_valid_r, out_valid_s;
  logic [OW-1:0]   outn_r, outn_s;
  logic            accept_s, last_s;
  logic [AW-1:0]   m_load_s;
  logic [A2E-1:0]  a2_ext_s;

  function automatic logic [AW-1:0] booth_pp(input logic [2:0] trip, input logic [AW-1:0] m);
    logic [AW-1:0] m2;
    m2 = m << 1;
    case (trip)
      3'b000, 3'b111: booth_pp = '0;
      3'b001, 3'b010: booth_pp = m;
      3'b011:         booth_pp = m2;
      3'b100:         booth_pp = -m2;
      3'b101, 3'b110: booth_pp = -m;
      default:        booth_pp = '0;
    endcase
  endfunction

  assign accept_s  = in_valid && in_ready_r;
  assign last_s    = (cnt_r == CW'(ITER - 1));
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign outn      = outn_r;

  // Operand extension, partial-product add and 2-bit arithmetic shift.
  always_comb begin
    m_load_s = '0;
    a2_ext_s = '0;
    if (sgn) begin
      m_load_s = {{2{a1[A1_LEN-1]}}, a1};
      a2_ext_s = {{XW{a2[A2_LEN-1]}}, a2};
    end else begin
      m_load_s = {2'b00, a1};
      a2_ext_s = {{XW{1'b0}}, a2};
    end
    pp_s     = booth_pp(p_r[2:0], m_r);
    sum_s    = {pp_s[AW-1], pp_s} + {p_r[PW-1], p_r[PW-1 -: AW]};
    // Sign bit of the AW+1-bit sum is duplicated once; the second copy would be redundant.
    p_next_s = {sum_s[AW], sum_s, p_r[A2E:2]};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = DONE;
        else        state_s = RUN;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered handshake and result outputs.
  always_comb begin
    in_ready_s  = in_ready_r;
    out_valid_s = out_valid_r;
    outn_s      = outn_r;
    case (state_r)
      IDLE: begin
        if (accept_s) in_ready_s = 1'b0;
        else          in_ready_s = 1'b1;
      end
      RUN: begin
        in_ready_s = 1'b0;
        if (last_s) begin
          out_valid_s = 1'b1;
          outn_s      = p_next_s[OW:1];
        end else begin
          out_valid_s = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          in_ready_s  = 1'b1;
        end else begin
          out_valid_s = 1'b1;
          in_ready_s  = 1'b0;
        end
      end
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      outn_r      <= '0;
      p_r         <= '0;
      m_r         <= '0;
      cnt_r       <= '0;
    end else begin
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      outn_r      <= outn_s;
      if (state_r == IDLE && accept_s) begin
        m_r   <= m_load_s;
        p_r   <= {{AW{1'b0}}, a2_ext_s, 1'b0};
        cnt_r <= '0;
      end else if (state_r == RUN) begin
        p_r   <= p_next_s;
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_boothmul_r4.sv
// Directed bench for boothmul_r4: 8x8, 8x7 (odd multiplier) and 32x32 instances.
module tb_boothmul_r4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_bus, b_bus;
  logic        sg, out_ready;
  logic        iv8, iv87, iv32;
  logic        ir8, ir87, ir32;
  logic        ov8, ov87, ov32;
  logic [15:0] outn8;
  logic [14:0] outn87;
  logic [63:0] outn32;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  boothmul_r4 #(.A1_LEN(8), .A2_LEN(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a1(a_bus[7:0]), .a2(b_bus[7:0]),
    .sgn(sg), .out_valid(ov8), .out_ready(out_ready), .outn(outn8));

  boothmul_r4 #(.A1_LEN(8), .A2_LEN(7)) u87 (
    .clk(clk), .rst(rst), .in_valid(iv87), .in_ready(ir87), .a1(a_bus[7:0]), .a2(b_bus[6:0]),
    .sgn(sg), .out_valid(ov87), .out_ready(out_ready), .outn(outn87));

  boothmul_r4 #(.A1_LEN(32), .A2_LEN(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a1(a_bus), .a2(b_bus),
    .sgn(sg), .out_valid(ov32), .out_ready(out_ready), .outn(outn32));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      0:       rdy = ir8;
      1:       rdy = ir87;
      default: rdy = ir32;
    endcase
  endfunction

  function automatic logic vld(input int sel);
    case (sel)
      0:       vld = ov8;
      1:       vld = ov87;
      default: vld = ov32;
    endcase
  endfunction

  function automatic logic [63:0] res(input int sel);
    case (sel)
      0:       res = {48'd0, outn8};
      1:       res = {49'd0, outn87};
      default: res = outn32;
    endcase
  endfunction

  task automatic set_iv(input int sel, input logic v);
    case (sel)
      0:       iv8  = v;
      1:       iv87 = v;
      default: iv32 = v;
    endcase
  endtask

  // Issue one op, then check latency and product; caller controls out_ready.
  task automatic do_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [63:0] exp, input int lat_exp, input string tag);
    int n;
    int lat;
    a_bus = a; b_bus = b; sg = s;
    set_iv(sel, 1'b1);
    n = 0;
    while (!rdy(sel) && n < 30) begin
      @(posedge clk); #1; n++;
    end
    check_eq({tag, "_ready"}, {63'd0, rdy(sel)}, 64'd1);
    @(posedge clk); #1;
    set_iv(sel, 1'b0);
    a_bus = ~a; b_bus = ~b; sg = ~s;
    lat = 0;
    while (!vld(sel) && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(lat_exp));
    check_eq({tag, "_prod"}, res(sel), exp);
  endtask

  initial begin
    int hits;
    rst = 1'b1; iv8 = 1'b0; iv87 = 1'b0; iv32 = 1'b0;
    a_bus = 32'd0; b_bus = 32'd0; sg = 1'b0; out_ready = 1'b1;
    #12;
    check_eq("rst_ready", {63'd0, ir8}, 64'd0);
    check_eq("rst_valid", {63'd0, ov8}, 64'd0);
    check_eq("rst_outn", {48'd0, outn8}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    check_eq("rel_ready0", {63'd0, ir8}, 64'd0);
    @(posedge clk); #1;
    check_eq("rel_ready1", {63'd0, ir8}, 64'd1);

    do_op(0, 32'h80, 32'h80, 1'b1, 64'h4000, 5, "s8_minmin");
    do_op(0, 32'hFF, 32'hFF, 1'b0, 64'hFE01, 5, "u8_ones");
    do_op(0, 32'hFF, 32'hFF, 1'b1, 64'h0001, 5, "s8_ones");
    do_op(1, 32'h80, 32'h40, 1'b1, 64'h2000, 4, "s87_min");
    do_op(1, 32'h80, 32'h40, 1'b0, 64'h2000, 4, "u87");
    do_op(1, 32'h7F, 32'h3F, 1'b0, 64'h1F41, 4, "u87_b");

    // Backpressure: product must hold while out_ready is low.
    out_ready = 1'b0;
    do_op(0, 32'd3, 32'd7, 1'b0, 64'd21, 5, "bp_op");
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ov8 && outn8 == 16'd21 && !ir8) hits++;
    end
    check_eq("bp_hold", 64'(hits), 64'd10);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_valid_fall", {63'd0, ov8}, 64'd0);
    check_eq("bp_ready_rise", {63'd0, ir8}, 64'd1);
    do_op(0, 32'hFF, 32'h7F, 1'b1, 64'hFF81, 5, "s8_neg");

    // Reset two edges into a run aborts it with no out_valid pulse.
    a_bus = 32'd5; b_bus = 32'd5; sg = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    check_eq("ab_ready", {63'd0, ir8}, 64'd1);
    @(posedge clk); #1 iv8 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check_eq("ab_outn", {48'd0, outn8}, 64'd0);
    check_eq("ab_valid", {63'd0, ov8}, 64'd0);
    check_eq("ab_ready0", {63'd0, ir8}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check_eq("ab_ready1", {63'd0, ir8}, 64'd1);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ov8) hits++;
    end
    check_eq("ab_no_valid", 64'(hits), 64'd0);
    do_op(0, 32'd3, 32'd5, 1'b0, 64'd15, 5, "ab_after");

    do_op(2, 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 17, "s32_minmin");
    do_op(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 17, "u32_ones");
    do_op(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001, 17, "s32_ones");
    do_op(2, 32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000, 17, "s32_maxmin");
    do_op(2, 32'h00000001, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFFFFFFFFFF, 17, "s32_one_neg");
    do_op(2, 32'h00000000, 32'h80000000, 1'b1, 64'h0000000000000000, 17, "s32_zero");
    do_op(2, 32'h00010001, 32'h0000FFFF, 1'b0, 64'h00000000FFFFFFFF, 17, "u32_mix");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
